instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//   Upstream neighbour of the controller in the mono_cpu_mips datapath.
//   - Holds the PC and fetches one instruction from instruction memory over a req/ready handshake.
//   - Presents the instruction to decode/controller with a valid/ready handshake.
//   - On retirement, computes the next PC from the controller's Jump and condition outputs and the register operands.
// PARAMETERS
//   RESET_PC   32'h0000_0000   PC loaded on reset; must be word-aligned.
//   DATA_W     32              instruction/address/operand width; only 32 is supported.
// PORTS
//   clk         in   1    rising-edge clock.
//   rst         in   1    asynchronous, active-high reset.
//   imem_req    out  1    fetch request to instruction memory.
//   imem_addr   out  32   fetch address; equals pc.
//   imem_ready  in   1    imem_rdata is valid this cycle; sampled only while imem_req=1.
//   imem_rdata  in   32   fetched instruction word.
//   inst        out  32   held instruction to the controller (op=[31:26], Rs=[25:21], Rt=[20:16], Shamt=[10:6], Func=[5:0]).
//   inst_valid  out  1    inst is valid and awaiting retirement.
//   inst_ready  in   1    execute retires inst this cycle.
//   pc          out  32   address of inst.
//   pc_plus4    out  32   pc+4, mod 2^32; feeds the link/branch datapath.
//   jump        in   1    Jump from the controller for inst.
//   condition   in   3    branch condition from the controller for inst.
//   rs_data     in   32   GPR[Rs] of inst.
//   rt_data     in   32   GPR[Rt] of inst.
// BEHAVIOUR
//   Reset (async, immediate): pc=RESET_PC, state=IDLE.
//     - imem_req=0, inst=0, inst_valid=0.
//     - A fetch or held instruction in progress is dropped.
//   FSM states: IDLE, FETCH, ISSUE.
//     IDLE  -> FETCH on the first clk edge after rst deasserts.
//     FETCH: imem_req=1, imem_addr=pc; address is stable until accepted.
//       - On imem_ready=1: inst<=imem_rdata, inst_valid<=1, go to ISSUE.
//       - Zero-wait memory (ready in the same cycle as req): inst_valid=1 on the next cycle.
//     ISSUE: imem_req=0; inst and pc are stable while inst_ready=0.
//       - On inst_ready=1: pc<=next_pc, inst_valid<=0, go to FETCH.
//   Throughput: at most one instruction per 2 cycles.
//   Ignored inputs: imem_ready outside FETCH; inst_ready outside ISSUE.
//   Condition decode (all compares signed, 32-bit):
//     000  none (no branch)
//     001  beq   rs==rt
//     010  bne   rs!=rt
//     011  bgez  rs>=0
//     100  bgtz  rs>0
//     101  blez  rs<=0
//     110  bltz  rs<0
//     111  reserved; treated as no branch.
//   Target computation:
//     br_tgt = pc_plus4 + (sext(inst[15:0])<<2)
//     j_tgt  = {pc_plus4[31:28], inst[25:0], 2'b00}
//   next_pc priority: jump=1 -> j_tgt; else condition taken -> br_tgt; else pc_plus4.
//   Arithmetic is 32-bit modulo: 0xFFFF_FFFC+4=0; negative offsets wrap through 0.
//   Branch inputs are sampled only on the retiring edge (ISSUE & inst_ready).
// TESTING
//   T1 reset/first fetch
//     - Stimulus: rst released; imem_ready=1 on first req, rdata=0x0000_0020.
//     - Response: imem_req=1 one cycle after release with addr=0; next cycle inst_valid=1, inst=0x20; after inst_ready, pc=4, imem_req=1.
//   T2 beq
//     - Stimulus: pc=0x40, inst=0x1000_0003, condition=001.
//     - Response: rs=rt=5 -> pc=0x50; rs=5, rt=6 -> pc=0x44.
//   T3 bltz backward/self-loop
//     - Stimulus: pc=0x100, inst imm=0xFFFF, condition=110.
//     - Response: rs=0x8000_0000 -> pc=0x100; rs=0 -> pc=0x104.
//   T4 jump priority
//     - Stimulus: pc=0x1000_0008, inst=0x0800_0010, jump=1, condition=001 with rs=rt.
//     - Response: pc=0x1000_0040.
//   T5 wrap
//     - Stimulus: pc=0xFFFF_FFFC, condition=000, jump=0, retire.
//     - Response: pc=0, imem_addr=0.
//   T6 stalls/reset
//     - Stimulus: imem_ready low 3 cycles; then inst_ready low 4 cycles; then rst pulsed mid-ISSUE.
//     - Response: imem_req and addr held during the memory stall; inst held during the retire stall; on rst, inst_valid=0 and pc=RESET_PC immediately.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//   Holds the PC and fetches one instruction at a time from instruction memory
//   over a req/ready handshake. It then presents that instruction to decode over
//   a valid/ready handshake. When the instruction retires, the unit computes the
//   next PC from the controller's jump/condition outputs and the operands.
//
// Ports
//   i_clk, i_rst      rising-edge clock, asynchronous active-high reset
//   o_imem_req        fetch request (asserted in FETCH)
//   o_imem_addr       fetch address, equals o_pc
//   i_imem_ready      i_imem_rdata valid this cycle (sampled only in FETCH)
//   i_imem_rdata      fetched instruction word
//   o_inst            held instruction
//   o_inst_valid      o_inst awaits retirement (ISSUE)
//   i_inst_ready      execute retires o_inst this cycle (sampled only in ISSUE)
//   o_pc, o_pc_plus4  address of o_inst and that address + 4 (mod 2^32)
//   i_jump            Jump decoded for o_inst
//   i_condition       branch condition decoded for o_inst
//   i_rs_data         GPR[Rs] of o_inst
//   i_rt_data         GPR[Rt] of o_inst
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DATA_W   = 32
) (
   input  logic              i_clk,
   input  logic              i_rst,
   output logic              o_imem_req,
   output logic [DATA_W-1:0] o_imem_addr,
   input  logic              i_imem_ready,
   input  logic [DATA_W-1:0] i_imem_rdata,
   output logic [DATA_W-1:0] o_inst,
   output logic              o_inst_valid,
   input  logic              i_inst_ready,
   output logic [DATA_W-1:0] o_pc,
   output logic [DATA_W-1:0] o_pc_plus4,
   input  logic              i_jump,
   input  logic [2:0]        i_condition,
   input  logic [DATA_W-1:0] i_rs_data,
   input  logic [DATA_W-1:0] i_rt_data
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      ISSUE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [DATA_W-1:0] r_pc;
   logic [DATA_W-1:0] r_inst;
   logic [DATA_W-1:0] w_pc_plus4;
   logic [DATA_W-1:0] w_br_tgt;
   logic [DATA_W-1:0] w_j_tgt;
   logic [DATA_W-1:0] w_next_pc;
   logic              w_taken;
   logic              w_rs_neg;
   logic              w_rs_zero;
   logic              w_fetch_done;
   logic              w_retire;

   assign w_fetch_done = (r_state == FETCH) && i_imem_ready;
   assign w_retire     = (r_state == ISSUE) && i_inst_ready;

   // Target arithmetic wraps modulo 2^32 naturally in 32-bit adders.
   assign w_pc_plus4 = r_pc + 32'd4;
   assign w_br_tgt   = w_pc_plus4 + {{14{r_inst[15]}}, r_inst[15:0], 2'b00};
   assign w_j_tgt    = {w_pc_plus4[31:28], r_inst[25:0], 2'b00};

   // Signed compares against zero reduce to sign bit and zero detect.
   assign w_rs_neg  = i_rs_data[DATA_W-1];
   assign w_rs_zero = (i_rs_data == 32'd0);

   // Branch condition decode; the reserved code never branches.
   always_comb begin
      w_taken = 1'b0;
      case (i_condition)
         3'b000:  w_taken = 1'b0;
         3'b001:  w_taken = (i_rs_data == i_rt_data);
         3'b010:  w_taken = (i_rs_data != i_rt_data);
         3'b011:  w_taken = ~w_rs_neg;
         3'b100:  w_taken = ~w_rs_neg & ~w_rs_zero;
         3'b101:  w_taken = w_rs_neg | w_rs_zero;
         3'b110:  w_taken = w_rs_neg;
         default: w_taken = 1'b0;
      endcase
   end

   // Next-PC select: jump outranks a taken branch.
   always_comb begin
      w_next_pc = w_pc_plus4;
      if (i_jump) begin
         w_next_pc = w_j_tgt;
      end else if (w_taken) begin
         w_next_pc = w_br_tgt;
      end else begin
         w_next_pc = w_pc_plus4;
      end
   end

   // FSM next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    w_state_nxt = FETCH;
         FETCH:   w_state_nxt = i_imem_ready ? ISSUE : FETCH;
         ISSUE:   w_state_nxt = i_inst_ready ? FETCH : ISSUE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // State, PC and instruction registers.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_pc    <= RESET_PC;
         r_inst  <= 32'd0;
      end else begin
         r_state <= w_state_nxt;
         if (w_fetch_done) begin
            r_inst <= i_imem_rdata;
         end
         if (w_retire) begin
            r_pc <= w_next_pc;
         end
      end
   end

   assign o_imem_req   = (r_state == FETCH);
   assign o_imem_addr  = r_pc;
   assign o_inst       = r_inst;
   assign o_inst_valid = (r_state == ISSUE);
   assign o_pc         = r_pc;
   assign o_pc_plus4   = w_pc_plus4;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//   Table-driven bench for instr_fetch_unit. Each table row fetches one
//   instruction with zero-wait memory and retires it with the given branch
//   inputs. It then checks the resulting PC against a hand-computed value.
//   Separate hand-written sequences cover reset, stalls and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

   typedef struct {
      logic [31:0] rdata;
      logic        jump;
      logic [2:0]  cond;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [31:0] exp_pc;
   } vec_t;

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] inst;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        jump;
   logic [2:0]  condition;
   logic [31:0] rs_data;
   logic [31:0] rt_data;

   int          n_cmp;
   int          n_err;
   logic [31:0] cur_pc;
   vec_t        tbl [21];

   instr_fetch_unit #(.RESET_PC(32'h0000_0000), .DATA_W(32)) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .o_imem_req   (imem_req),
      .o_imem_addr  (imem_addr),
      .i_imem_ready (imem_ready),
      .i_imem_rdata (imem_rdata),
      .o_inst       (inst),
      .o_inst_valid (inst_valid),
      .i_inst_ready (inst_ready),
      .o_pc         (pc),
      .o_pc_plus4   (pc_plus4),
      .i_jump       (jump),
      .i_condition  (condition),
      .i_rs_data    (rs_data),
      .i_rt_data    (rt_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_req();
      int n;
      n = 0;
      while (imem_req !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      n_cmp++;
      if (imem_req !== 1'b1) begin
         n_err++;
         $display("FAIL req_timeout: imem_req stayed %b, expected 1", imem_req);
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      wait_req();
      chk($sformatf("v%0d_addr", idx), imem_addr, cur_pc);
      chk($sformatf("v%0d_valid_pre", idx), {31'd0, inst_valid}, 32'd0);
      imem_ready = 1'b1;
      imem_rdata = v.rdata;
      tick();
      imem_ready = 1'b0;
      imem_rdata = 32'hA5A5_A5A5;
      chk($sformatf("v%0d_valid", idx), {31'd0, inst_valid}, 32'd1);
      chk($sformatf("v%0d_inst", idx), inst, v.rdata);
      chk($sformatf("v%0d_pc", idx), pc, cur_pc);
      chk($sformatf("v%0d_pc4", idx), pc_plus4, cur_pc + 32'd4);
      chk($sformatf("v%0d_req_issue", idx), {31'd0, imem_req}, 32'd0);
      jump       = v.jump;
      condition  = v.cond;
      rs_data    = v.rs;
      rt_data    = v.rt;
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
      jump       = ~v.jump;
      condition  = ~v.cond;
      rs_data    = ~v.rs;
      rt_data    = 32'h1357_9BDF;
      chk($sformatf("v%0d_next_pc", idx), pc, v.exp_pc);
      chk($sformatf("v%0d_next_addr", idx), imem_addr, v.exp_pc);
      chk($sformatf("v%0d_req_after", idx), {31'd0, imem_req}, 32'd1);
      chk($sformatf("v%0d_valid_after", idx), {31'd0, inst_valid}, 32'd0);
      cur_pc = v.exp_pc;
   endtask

   initial begin
      n_cmp      = 0;
      n_err      = 0;
      rst        = 1'b1;
      imem_ready = 1'b0;
      imem_rdata = 32'd0;
      inst_ready = 1'b0;
      jump       = 1'b0;
      condition  = 3'b000;
      rs_data    = 32'd0;
      rt_data    = 32'd0;
      cur_pc     = 32'd0;

      //            rdata          j     cond    rs             rt            exp_pc
      tbl[0]  = '{32'h0000_0020, 1'b0, 3'b000, 32'd0,         32'd0,        32'h0000_0004};
      tbl[1]  = '{32'h0800_0010, 1'b1, 3'b000, 32'd0,         32'd0,        32'h0000_0040};
      tbl[2]  = '{32'h1000_0003, 1'b0, 3'b001, 32'd5,         32'd5,        32'h0000_0050};
      tbl[3]  = '{32'h0800_0010, 1'b1, 3'b000, 32'd0,         32'd0,        32'h0000_0040};
      tbl[4]  = '{32'h1000_0003, 1'b0, 3'b001, 32'd5,         32'd6,        32'h0000_0044};
      tbl[5]  = '{32'h0800_0040, 1'b1, 3'b000, 32'd0,         32'd0,        32'h0000_0100};
      tbl[6]  = '{32'h0400_FFFF, 1'b0, 3'b110, 32'h8000_0000, 32'd0,        32'h0000_0100};
      tbl[7]  = '{32'h0400_FFFF, 1'b0, 3'b110, 32'd0,         32'd0,        32'h0000_0104};
      tbl[8]  = '{32'h1422_0004, 1'b0, 3'b010, 32'd1,         32'd2,        32'h0000_0118};
      tbl[9]  = '{32'h0401_0001, 1'b0, 3'b011, 32'd0,         32'd0,        32'h0000_0120};
      tbl[10] = '{32'h1C00_0001, 1'b0, 3'b100, 32'd0,         32'd0,        32'h0000_0124};
      tbl[11] = '{32'h1800_0002, 1'b0, 3'b101, 32'hFFFF_FFFF, 32'd0,        32'h0000_0130};
      tbl[12] = '{32'h1000_0005, 1'b0, 3'b111, 32'd3,         32'd3,        32'h0000_0134};
      tbl[13] = '{32'h1C00_0003, 1'b0, 3'b100, 32'd1,         32'd0,        32'h0000_0144};
      tbl[14] = '{32'h0401_0001, 1'b0, 3'b011, 32'h8000_0000, 32'd0,        32'h0000_0148};
      tbl[15] = '{32'h0BFF_FFFF, 1'b1, 3'b000, 32'd0,         32'd0,        32'h0FFF_FFFC};
      tbl[16] = '{32'h0000_0000, 1'b0, 3'b000, 32'd0,         32'd0,        32'h1000_0000};
      tbl[17] = '{32'h0800_0002, 1'b1, 3'b000, 32'd0,         32'd0,        32'h1000_0008};
      tbl[18] = '{32'h0800_0010, 1'b1, 3'b001, 32'd7,         32'd7,        32'h1000_0040};
      tbl[19] = '{32'h1000_FFFE, 1'b0, 3'b001, 32'd0,         32'd0,        32'hFFFF_FFFC};
      tbl[20] = '{32'h0000_0000, 1'b0, 3'b000, 32'd0,         32'd0,        32'h0000_0000};

      // Reset state and first fetch
      #1;
      chk("rst_valid", {31'd0, inst_valid}, 32'd0);
      chk("rst_inst", inst, 32'd0);
      chk("rst_pc", pc, 32'd0);
      tick();
      tick();
      rst = 1'b0;
      chk("idle_req", {31'd0, imem_req}, 32'd0);
      tick();
      chk("t1_req", {31'd0, imem_req}, 32'd1);
      chk("t1_addr", imem_addr, 32'd0);

      for (int i = 0; i <= 18; i++) begin
         run_vec(tbl[i], i);
      end

      // Memory stall: inst_ready/jump must be ignored in FETCH
      wait_req();
      for (int k = 0; k < 3; k++) begin
         inst_ready = 1'b1;
         jump       = 1'b1;
         tick();
         chk("stall_req", {31'd0, imem_req}, 32'd1);
         chk("stall_addr", imem_addr, cur_pc);
         chk("stall_valid", {31'd0, inst_valid}, 32'd0);
      end
      inst_ready = 1'b0;
      jump       = 1'b0;
      imem_ready = 1'b1;
      imem_rdata = 32'h1234_5678;
      tick();
      // Retire stall: new memory data must not disturb the held instruction
      for (int k = 0; k < 4; k++) begin
         imem_ready = 1'b1;
         imem_rdata = 32'hDEAD_BEEF;
         tick();
         chk("hold_valid", {31'd0, inst_valid}, 32'd1);
         chk("hold_inst", inst, 32'h1234_5678);
         chk("hold_pc", pc, cur_pc);
         chk("hold_req", {31'd0, imem_req}, 32'd0);
      end
      imem_ready = 1'b0;

      // Asynchronous reset mid-ISSUE takes effect without a clock edge
      #2;
      rst = 1'b1;
      #1;
      chk("arst_valid", {31'd0, inst_valid}, 32'd0);
      chk("arst_pc", pc, 32'd0);
      chk("arst_inst", inst, 32'd0);
      chk("arst_req", {31'd0, imem_req}, 32'd0);
      tick();
      rst    = 1'b0;
      cur_pc = 32'd0;

      // Wrap through 0xFFFF_FFFC
      for (int i = 19; i <= 20; i++) begin
         run_vec(tbl[i], i);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
